spi_mul_unit: RTL and testbench

- Parametrised serial multiplier peripheral. It is the next generation of the SPI-attached multiply block on the processor's peripheral bus.
- An SPI master shifts in an opcode and two WIDTH-bit operands in one frame. The block computes with an iterative shift-add multiplier, then returns a 2*WIDTH-bit result in a second frame.
- New relative to the previous generation: width parameter, signed/unsigned/low-half modes, sclk edge detection with synchronisers, frame abort, busy/error status.

---
 rtl/spi_mul_pkg.sv | 25 ++
 rtl/spi_mul_unit_if.sv | 12 +
 rtl/seq_mul.sv | 73 +++++++
 rtl/spi_mul_unit.sv | 217 +++++++++++++++++++++
 tb/tb_spi_mul_unit.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mul_pkg.sv
// Shared types and constants for the SPI-attached multiplier.
package spi_mul_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_MULU  = 3'b000,
    OP_MULS  = 3'b001,
    OP_MULLO = 3'b010
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_COMPUTE,
    ST_WAIT,
    ST_SEND
  } state_e;

  // Opcodes above MULLO have no defined operation.
  function automatic logic op_reserved(logic [OPC_W-1:0] op);
    return (op > OPC_W'(OP_MULLO));
  endfunction

endpackage

// File: rtl/spi_mul_unit_if.sv
// SPI pins plus status lines of the multiplier peripheral.
interface spi_mul_unit_if;
  logic nss;
  logic sclk;
  logic mosi;
  logic miso;
  logic busy;
  logic err;

  modport master (output nss, sclk, mosi, input miso, busy, err);
  modport slave  (input nss, sclk, mosi, output miso, busy, err);
endinterface

// File: rtl/seq_mul.sv
// Unsigned iterative shift-add multiplier: one partial product per clock.
module seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic               run_q, run_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               done_q, done_d;

  // Load operands on start, then add/shift until the down-counter hits one.
  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    done_d   = 1'b0;
    if (start && !run_q) begin
      run_d    = 1'b1;
      cnt_d    = CNT_W'(WIDTH);
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      done_q   <= 1'b0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/spi_mul_unit.sv
// SPI-attached multiplier: receive opcode + operands, multiply, send result.
//
//   state      | meaning
//   IDLE       | waiting for chip select to fall
//   RECEIVE    | shifting in opcode, opa, opb on sclk rise
//   COMPUTE    | multiplier running, busy high, SPI ignored
//   WAIT       | result held, waiting for a fresh chip-select fall
//   SEND       | shifting result out on miso, MSB first
module spi_mul_unit
  import spi_mul_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic           clock,
  input logic           reset,
  spi_mul_unit_if.slave bus
);

  localparam int FRAME = OPC_W + 2 * WIDTH;
  localparam int CNT_W = $clog2(FRAME);
  localparam int SW    = SYNC_STAGES + 1;

  // One extra stage beyond the synchroniser gives the previous sample for edges.
  logic [SW-1:0]          nss_sync_q, nss_sync_d;
  logic [SW-1:0]          sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic nss_fall, nss_rise, sclk_rise, sclk_fall, mosi_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME-2:0]   rx_q, rx_d;
  logic [FRAME-1:0]   rx_next;
  logic [OPC_W-1:0]   opc_in;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_in, b_in;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic               neg_q, neg_d, start_q, start_d;
  logic [2*WIDTH-1:0] res_q, res_d, prod, prod_fmt;
  logic               miso_q, miso_d, busy_q, busy_d, err_q, err_d;
  logic               mul_done;

  // Synchroniser shift chains and edge pulses.
  always_comb begin
    nss_sync_d  = (nss_sync_q << 1) | SW'(bus.nss);
    sclk_sync_d = (sclk_sync_q << 1) | SW'(bus.sclk);
    mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(bus.mosi);
    nss_fall    = nss_sync_q[SW-1] & ~nss_sync_q[SW-2];
    nss_rise    = ~nss_sync_q[SW-1] & nss_sync_q[SW-2];
    sclk_rise   = ~sclk_sync_q[SW-1] & sclk_sync_q[SW-2];
    sclk_fall   = sclk_sync_q[SW-1] & ~sclk_sync_q[SW-2];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  end

  // Frame fields as they will look once the bit arriving now is shifted in.
  always_comb begin
    rx_next = {rx_q, mosi_s};
    opc_in  = rx_next[FRAME-1 -: OPC_W];
    a_in    = rx_next[2*WIDTH-1 -: WIDTH];
    b_in    = rx_next[WIDTH-1:0];
  end

  // Result formatting: sign restore for MULS, upper half cleared for MULLO.
  always_comb begin
    case (op_q)
      OP_MULS:  prod_fmt = neg_q ? -prod : prod;
      OP_MULLO: prod_fmt = {{WIDTH{1'b0}}, prod[WIDTH-1:0]};
      default:  prod_fmt = prod;
    endcase
  end

  seq_mul #(.WIDTH(WIDTH)) u_seq_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (start_q),
    .a       (mag_a_q),
    .b       (mag_b_q),
    .done    (mul_done),
    .product (prod)
  );

  // Next-state and output logic of the frame sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    op_d    = op_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    start_d = 1'b0;
    res_d   = res_q;
    miso_d  = miso_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (nss_fall) begin
          state_d = ST_RECEIVE;
          cnt_d   = '0;
          rx_d    = '0;
        end
      end
      ST_RECEIVE: begin
        // The final bit wins over a simultaneous chip-select release.
        if (sclk_rise && cnt_q == CNT_W'(FRAME - 1)) begin
          state_d = ST_COMPUTE;
          busy_d  = 1'b1;
          cnt_d   = '0;
          rx_d    = rx_next[FRAME-2:0];
          err_d   = op_reserved(opc_in);
          if (!op_reserved(opc_in)) begin
            op_d    = op_e'(opc_in);
            start_d = 1'b1;
            if (op_e'(opc_in) == OP_MULS) begin
              mag_a_d = a_in[WIDTH-1] ? -a_in : a_in;
              mag_b_d = b_in[WIDTH-1] ? -b_in : b_in;
              neg_d   = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            end else begin
              mag_a_d = a_in;
              mag_b_d = b_in;
              neg_d   = 1'b0;
            end
          end
        end else if (nss_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rx_d    = '0;
        end else if (sclk_rise) begin
          rx_d  = rx_next[FRAME-2:0];
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMPUTE: begin
        // err_q was set on acceptance, so a reserved opcode skips the core.
        if (err_q) begin
          state_d = ST_WAIT;
          busy_d  = 1'b0;
          res_d   = '0;
        end else if (mul_done) begin
          state_d = ST_WAIT;
          busy_d  = 1'b0;
          res_d   = prod_fmt;
        end
      end
      ST_WAIT: begin
        if (nss_fall) begin
          state_d = ST_SEND;
          cnt_d   = '0;
          miso_d  = res_q[2*WIDTH-1];
        end
      end
      ST_SEND: begin
        if (nss_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
        end else if (sclk_fall) begin
          res_d  = res_q << 1;
          miso_d = res_q[2*WIDTH-2];
        end else if (sclk_rise) begin
          if (cnt_q == CNT_W'(2 * WIDTH - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All registers, asynchronously cleared; nss chain idles high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nss_sync_q  <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      op_q        <= OP_MULU;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      neg_q       <= 1'b0;
      start_q     <= 1'b0;
      res_q       <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      nss_sync_q  <= nss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      op_q        <= op_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      neg_q       <= neg_d;
      start_q     <= start_d;
      res_q       <= res_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.miso = miso_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_spi_mul_unit.sv
// Bench for spi_mul_unit: WIDTH=8 and WIDTH=32 instances, driven one at a time.
module tb_spi_mul_unit;

  localparam int H = 5;  // sclk half period in system clocks

  logic clock = 1'b0;
  logic rst_n;
  logic sel;
  logic nss_drv, sclk_drv, mosi_drv;
  logic cur_miso, cur_busy, cur_err;
  logic watch;
  logic err_model;
  int   n_cmp = 0;
  int   n_bad = 0;

  spi_mul_unit_if if8 ();
  spi_mul_unit_if if32 ();

  assign if8.nss   = sel ? 1'b1 : nss_drv;
  assign if8.sclk  = sel ? 1'b0 : sclk_drv;
  assign if8.mosi  = sel ? 1'b0 : mosi_drv;
  assign if32.nss  = sel ? nss_drv  : 1'b1;
  assign if32.sclk = sel ? sclk_drv : 1'b0;
  assign if32.mosi = sel ? mosi_drv : 1'b0;
  assign cur_miso  = sel ? if32.miso : if8.miso;
  assign cur_busy  = sel ? if32.busy : if8.busy;
  assign cur_err   = sel ? if32.err  : if8.err;

  spi_mul_unit #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clock (clock),
    .reset (rst_n),
    .bus   (if8)
  );

  spi_mul_unit #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
    .clock (clock),
    .reset (rst_n),
    .bus   (if32)
  );

  // System clock.
  always #5 clock = ~clock;

  // Expected result from the arithmetic definition of each opcode.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    logic [63:0] wmask, rmask, ua, ub, p;
    longint sa, sb;
    wmask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    rmask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    ua = {32'b0, a} & wmask;
    ub = {32'b0, b} & wmask;
    case (op)
      3'd0: p = (ua * ub) & rmask;
      3'd1: begin
        sa = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
        sb = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
        p  = sa * sb;
        p  = p & rmask;
      end
      3'd2: p = (ua * ub) & wmask;
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Compare process: whenever the bus is idle, outputs must be quiet and err must match the model.
  always @(negedge clock) begin
    if (watch) begin
      n_cmp++;
      if (cur_busy !== 1'b0 || cur_miso !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_quiet: busy=%b miso=%b expected 0/0", cur_busy, cur_miso);
      end
      n_cmp++;
      if (cur_err !== err_model) begin
        n_bad++;
        $display("FAIL idle_err: got %b expected %b", cur_err, err_model);
      end
    end
  end

  // Receive frame, leaving sclk high after the final rise and nss low.
  task automatic send_frame(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int w);
    logic [66:0] f;
    logic [31:0] m;
    int n;
    n = 3 + 2 * w;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    f = (67'(op) << (2 * w)) | (67'(a & m) << w) | 67'(b & m);
    nss_drv = 1'b0;
    wait_clk(H);
    for (int i = n - 1; i >= 0; i--) begin
      mosi_drv = f[i];
      wait_clk(H);
      sclk_drv = 1'b1;
      if (i > 0) begin
        wait_clk(H);
        sclk_drv = 1'b0;
      end
    end
  endtask

  // Count negedges with busy high; bounded so a stuck busy still terminates.
  task automatic measure_busy(output int hi, output bit seen);
    hi   = 0;
    seen = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clock);
      if (cur_busy) begin
        seen = 1'b1;
        hi++;
      end else if (seen) begin
        break;
      end
    end
  endtask

  task automatic read_frame(input int w, output logic [63:0] got);
    got = '0;
    nss_drv = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 2 * w; i++) begin
      got = {got[62:0], cur_miso};
      sclk_drv = 1'b1;
      wait_clk(H);
      sclk_drv = 1'b0;
      wait_clk(H);
    end
    nss_drv = 1'b1;
    wait_clk(H);
  endtask

  task automatic run_op(input bit s, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit has_lit, input logic [63:0] lit,
                        input string nm);
    int w, hi;
    bit seen, rsv;
    logic [63:0] got, exp;
    sel = s;
    w   = s ? 32 : 8;
    rsv = (op > 3'd2);
    send_frame(op, a, b, w);
    measure_busy(hi, seen);
    check({nm, "_busy_seen"}, 64'(seen), 64'd1);
    if (rsv) begin
      n_cmp++;
      if (hi < 1 || hi > 2) begin
        n_bad++;
        $display("FAIL %s_busy_len: got %0d clocks expected 1..2", nm, hi);
      end
    end else begin
      check({nm, "_busy_len"}, 64'(hi), 64'(w + 2));
    end
    sclk_drv = 1'b0;
    wait_clk(H);
    nss_drv = 1'b1;
    wait_clk(H);
    err_model = rsv;
    exp = model(op, a, b, w);
    check({nm, "_err"}, 64'(cur_err), 64'(err_model));
    read_frame(w, got);
    check({nm, "_model"}, got, exp);
    if (has_lit) check({nm, "_lit"}, got, lit);
    watch = 1'b1;
    wait_clk(8);
    watch = 1'b0;
  endtask

  // Hard time limit.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    sel = 1'b0; nss_drv = 1'b1; sclk_drv = 1'b0; mosi_drv = 1'b0;
    watch = 1'b0; err_model = 1'b0;
    rst_n = 1'b0;
    wait_clk(3);
    check("rst_busy8",  64'(if8.busy),  64'd0);
    check("rst_miso8",  64'(if8.miso),  64'd0);
    check("rst_err8",   64'(if8.err),   64'd0);
    check("rst_busy32", 64'(if32.busy), 64'd0);
    check("rst_miso32", 64'(if32.miso), 64'd0);
    check("rst_err32",  64'(if32.err),  64'd0);
    rst_n = 1'b1;
    wait_clk(3);

    run_op(1'b0, 3'd0, 32'h03, 32'h05, 1'b1, 64'h000F, "mulu_3x5");
    run_op(1'b0, 3'd1, 32'hFD, 32'h05, 1'b1, 64'hFFF1, "muls_m3x5");
    run_op(1'b0, 3'd1, 32'h80, 32'h80, 1'b1, 64'h4000, "muls_min_sq");
    run_op(1'b0, 3'd2, 32'hFF, 32'hFF, 1'b1, 64'h0001, "mullo_ff");
    run_op(1'b0, 3'd1, 32'h7F, 32'h80, 1'b1, 64'hC080, "muls_max_min");
    run_op(1'b0, 3'd0, 32'hFF, 32'hFF, 1'b1, 64'hFE01, "mulu_ff");
    run_op(1'b0, 3'd2, 32'h12, 32'h34, 1'b1, 64'h00A8, "mullo_12x34");
    run_op(1'b0, 3'd1, 32'h00, 32'h80, 1'b0, 64'h0,    "muls_zero");
    run_op(1'b0, 3'd5, 32'h12, 32'h34, 1'b1, 64'h0000, "reserved_101");

    // Abort after 10 receive bits: no busy, err keeps its value.
    sel = 1'b0;
    nss_drv = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 10; i++) begin
      mosi_drv = i[0];
      wait_clk(H);
      sclk_drv = 1'b1;
      wait_clk(H);
      sclk_drv = 1'b0;
    end
    wait_clk(H);
    nss_drv = 1'b1;
    watch = 1'b1;
    wait_clk(40);
    watch = 1'b0;
    check("abort_err_kept", 64'(if8.err), 64'd1);
    run_op(1'b0, 3'd0, 32'h02, 32'h07, 1'b1, 64'h000E, "mulu_after_abort");

    // Reset in the middle of COMPUTE.
    sel = 1'b0;
    send_frame(3'd0, 32'h0C, 32'h0B, 8);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (if8.busy) seen = 1'b1;
    end
    check("rstc_busy_seen", 64'(seen), 64'd1);
    wait_clk(3);
    rst_n = 1'b0;
    #1;
    check("rstc_busy", 64'(if8.busy), 64'd0);
    check("rstc_miso", 64'(if8.miso), 64'd0);
    check("rstc_err",  64'(if8.err),  64'd0);
    sclk_drv = 1'b0;
    nss_drv  = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    err_model = 1'b0;
    wait_clk(3);
    run_op(1'b0, 3'd0, 32'h0C, 32'h0B, 1'b1, 64'h0084, "fresh_after_rst");

    run_op(1'b1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001, "w32_mulu_sq");
    run_op(1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "w32_muls_min");
    run_op(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, "w32_muls_m1x5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
